// File: rtl/vga_pkg.sv
// Shared VGA timing constants and helpers for the timing generator.
package vga_pkg;

    // Default 640x480 timing (pixels / lines)
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 29;

    // Sync polarity: the value is the level-inversion applied to "sync active"
    typedef enum logic {
        POL_ACTIVE_HIGH = 1'b0,
        POL_ACTIVE_LOW  = 1'b1
    } sync_pol_e;

    // Counts per line or per frame
    function automatic int axis_total(input int sync, input int bp,
                                      input int active, input int fp);
        return sync + bp + active + fp;
    endfunction

    // Pin level for a sync signal given whether the pulse is active
    function automatic logic sync_level(input logic act, input logic act_low);
        return act ^ act_low;
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping counter plus sync/active-window decodes.
// Region order from count 0: sync, back porch, active, front porch.
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int TOTAL  = 800,
    parameter int SYNC   = 96,
    parameter int BP     = 48,
    parameter int ACTIVE = 640,
    parameter int W      = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         tick,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         wrap,
    output logic         sync_act,
    output logic         active,
    output logic [W-1:0] offset
);

    localparam logic [W-1:0] LAST   = W'(TOTAL - 1);
    localparam logic [W-1:0] SYNC_W = W'(SYNC);
    localparam logic [W-1:0] A_LO   = W'(SYNC + BP);
    localparam logic [W-1:0] A_HI   = W'(SYNC + BP + ACTIVE - 1);

    // Advance on enabled ticks, wrapping after the last count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (tick && inc)
            count <= (count == LAST) ? '0 : count + W'(1);
    end

    // Combinational decodes of the current count
    always_comb begin
        wrap     = inc && (count == LAST);
        sync_act = (count < SYNC_W);
        active   = (count >= A_LO) && (count <= A_HI);
        offset   = active ? (count - A_LO) : '0;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA sync/timing generator driven by a pixel-enable strobe.
// Internal counters lead the registered outputs by one pix_en tick; every
// output is decoded from the same (h_cnt, v_cnt) pair so they stay aligned.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_ACTIVE      = DEF_H_ACTIVE,
    parameter int H_FP          = DEF_H_FP,
    parameter int H_SYNC        = DEF_H_SYNC,
    parameter int H_BP          = DEF_H_BP,
    parameter int V_ACTIVE      = DEF_V_ACTIVE,
    parameter int V_FP          = DEF_V_FP,
    parameter int V_SYNC        = DEF_V_SYNC,
    parameter int V_BP          = DEF_V_BP,
    parameter int HS_ACTIVE_LOW = 1,
    parameter int VS_ACTIVE_LOW = 1,
    parameter int H_W           = 10,
    parameter int V_W           = 10
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           pix_en,
    output logic [H_W-1:0] hcs,
    output logic [V_W-1:0] vcs,
    output logic           hsync,
    output logic           vsync,
    output logic           activevideo,
    output logic [H_W-1:0] x,
    output logic [V_W-1:0] y,
    output logic           line_start,
    output logic           frame_start
);

    localparam int   H_TOTAL = axis_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int   V_TOTAL = axis_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam logic HS_LOW  = (HS_ACTIVE_LOW != 0);
    localparam logic VS_LOW  = (VS_ACTIVE_LOW != 0);

    // Counter widths must hold the full line/frame count
    if (H_TOTAL > (1 << H_W)) begin : g_h_w_too_narrow
        $error("vga_timing_gen: H_W too narrow for H_TOTAL");
    end
    if (V_TOTAL > (1 << V_W)) begin : g_v_w_too_narrow
        $error("vga_timing_gen: V_W too narrow for V_TOTAL");
    end

    logic [H_W-1:0] h_cnt, h_off;
    logic [V_W-1:0] v_cnt, v_off;
    logic           h_wrap, h_sync_act, h_act;
    logic           v_sync_act, v_act;
    logic           win;

    vga_axis_counter #(
        .TOTAL(H_TOTAL), .SYNC(H_SYNC), .BP(H_BP), .ACTIVE(H_ACTIVE), .W(H_W)
    ) u_h (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (pix_en),
        .inc     (1'b1),
        .count   (h_cnt),
        .wrap    (h_wrap),
        .sync_act(h_sync_act),
        .active  (h_act),
        .offset  (h_off)
    );

    // Vertical axis steps only when the line wraps
    vga_axis_counter #(
        .TOTAL(V_TOTAL), .SYNC(V_SYNC), .BP(V_BP), .ACTIVE(V_ACTIVE), .W(V_W)
    ) u_v (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (pix_en),
        .inc     (h_wrap),
        .count   (v_cnt),
        .wrap    (),
        .sync_act(v_sync_act),
        .active  (v_act),
        .offset  (v_off)
    );

    assign win = h_act && v_act;

    // Output stage: capture the current pixel and its decodes on each tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcs         <= '0;
            vcs         <= '0;
            hsync       <= HS_LOW;
            vsync       <= VS_LOW;
            activevideo <= 1'b0;
            x           <= '0;
            y           <= '0;
        end else if (pix_en) begin
            hcs         <= h_cnt;
            vcs         <= v_cnt;
            hsync       <= sync_level(h_sync_act, HS_LOW);
            vsync       <= sync_level(v_sync_act, VS_LOW);
            activevideo <= win;
            x           <= win ? h_off : '0;
            y           <= win ? v_off : '0;
        end
    end

    // Strobes: one clk wide, cleared on the following edge whatever pix_en is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            line_start  <= pix_en && (h_cnt == '0);
            frame_start <= pix_en && (h_cnt == '0) && (v_cnt == '0);
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen: three instances (default timing,
// a mid-size timing for full-frame checks, a tiny active-high-hsync timing).
// Reference model maps the number of pix_en ticks since reset to a pixel index.
module tb_vga_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [9:0] hcs, vcs;
        logic       hs, vs, av;
        logic [9:0] x, y;
        logic       ls, fs;
    } px_t;

    // ---------------- instance A: default 640x480 ----------------
    logic rst_a, en_a;
    logic [9:0] hcs_a, vcs_a, x_a, y_a;
    logic hs_a, vs_a, av_a, ls_a, fs_a;
    vga_timing_gen u_a (
        .clk(clk), .rst_n(rst_a), .pix_en(en_a), .hcs(hcs_a), .vcs(vcs_a),
        .hsync(hs_a), .vsync(vs_a), .activevideo(av_a), .x(x_a), .y(y_a),
        .line_start(ls_a), .frame_start(fs_a)
    );

    // ---------------- instance B: H 64/4/12/8, V 48/2/2/3 ----------------
    logic rst_b, en_b;
    logic [6:0] hcs_b, x_b;
    logic [5:0] vcs_b, y_b;
    logic hs_b, vs_b, av_b, ls_b, fs_b;
    vga_timing_gen #(
        .H_ACTIVE(64), .H_FP(4), .H_SYNC(12), .H_BP(8),
        .V_ACTIVE(48), .V_FP(2), .V_SYNC(2), .V_BP(3),
        .HS_ACTIVE_LOW(1), .VS_ACTIVE_LOW(1), .H_W(7), .V_W(6)
    ) u_b (
        .clk(clk), .rst_n(rst_b), .pix_en(en_b), .hcs(hcs_b), .vcs(vcs_b),
        .hsync(hs_b), .vsync(vs_b), .activevideo(av_b), .x(x_b), .y(y_b),
        .line_start(ls_b), .frame_start(fs_b)
    );

    // ---------------- instance C: H 8/2/2/2, V 4/1/1/1, hsync active high ----------------
    logic rst_c, en_c;
    logic [3:0] hcs_c, x_c;
    logic [2:0] vcs_c, y_c;
    logic hs_c, vs_c, av_c, ls_c, fs_c;
    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_ACTIVE_LOW(0), .VS_ACTIVE_LOW(1), .H_W(4), .V_W(3)
    ) u_c (
        .clk(clk), .rst_n(rst_c), .pix_en(en_c), .hcs(hcs_c), .vcs(vcs_c),
        .hsync(hs_c), .vsync(vs_c), .activevideo(av_c), .x(x_c), .y(y_c),
        .line_start(ls_c), .frame_start(fs_c)
    );

    // ---------------- reference model ----------------
    // k = pix_en ticks since reset release; output shows pixel index k-1.
    int k_a, k_b, k_c;
    bit last_a, last_b, last_c;

    function automatic px_t model(input int k, input bit last_en,
                                  input int hsy, input int hbp, input int hact, input int hfp,
                                  input int vsy, input int vbp, input int vact, input int vfp,
                                  input bit hlow, input bit vlow);
        px_t e;
        int ht, vt, p, h, v;
        bit hin, vin;
        ht = hsy + hbp + hact + hfp;
        vt = vsy + vbp + vact + vfp;
        e = '0;
        if (k == 0) begin
            e.hs = hlow;
            e.vs = vlow;
            return e;
        end
        p = (k - 1) % (ht * vt);
        h = p % ht;
        v = p / ht;
        hin = (h >= hsy + hbp) && (h < hsy + hbp + hact);
        vin = (v >= vsy + vbp) && (v < vsy + vbp + vact);
        e.hcs = 10'(h);
        e.vcs = 10'(v);
        e.hs  = (h < hsy) ? !hlow : hlow;
        e.vs  = (v < vsy) ? !vlow : vlow;
        e.av  = hin && vin;
        e.x   = e.av ? 10'(h - hsy - hbp) : 10'd0;
        e.y   = e.av ? 10'(v - vsy - vbp) : 10'd0;
        e.ls  = last_en && (h == 0);
        e.fs  = e.ls && (v == 0);
        return e;
    endfunction

    function automatic px_t exp_a();
        return model(k_a, last_a, 96, 48, 640, 16, 2, 29, 480, 10, 1'b1, 1'b1);
    endfunction
    function automatic px_t exp_b();
        return model(k_b, last_b, 12, 8, 64, 4, 2, 3, 48, 2, 1'b1, 1'b1);
    endfunction
    function automatic px_t exp_c();
        return model(k_c, last_c, 2, 2, 8, 2, 1, 1, 4, 1, 1'b0, 1'b1);
    endfunction

    function automatic px_t obs_a();
        px_t o;
        o.hcs = hcs_a; o.vcs = vcs_a; o.hs = hs_a; o.vs = vs_a; o.av = av_a;
        o.x = x_a; o.y = y_a; o.ls = ls_a; o.fs = fs_a;
        return o;
    endfunction
    function automatic px_t obs_b();
        px_t o;
        o.hcs = 10'(hcs_b); o.vcs = 10'(vcs_b); o.hs = hs_b; o.vs = vs_b; o.av = av_b;
        o.x = 10'(x_b); o.y = 10'(y_b); o.ls = ls_b; o.fs = fs_b;
        return o;
    endfunction
    function automatic px_t obs_c();
        px_t o;
        o.hcs = 10'(hcs_c); o.vcs = 10'(vcs_c); o.hs = hs_c; o.vs = vs_c; o.av = av_c;
        o.x = 10'(x_c); o.y = 10'(y_c); o.ls = ls_c; o.fs = fs_c;
        return o;
    endfunction

    // One clock: inputs were driven at the previous negedge; sample at next negedge
    task automatic step();
        @(posedge clk);
        if (!rst_a) begin k_a = 0; last_a = 0; end else begin last_a = en_a; if (en_a) k_a++; end
        if (!rst_b) begin k_b = 0; last_b = 0; end else begin last_b = en_b; if (en_b) k_b++; end
        if (!rst_c) begin k_c = 0; last_c = 0; end else begin last_c = en_c; if (en_c) k_c++; end
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        px_t o, e;
        rst_a = 0; rst_b = 0; rst_c = 0;
        en_a = 1; en_b = 1; en_c = 1;
        @(negedge clk);
        step(); step();
        o = obs_a(); e = exp_a(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_a got %h want %h", o, e); end
        o = obs_b(); e = exp_b(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_b got %h want %h", o, e); end
        o = obs_c(); e = exp_c(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_c got %h want %h", o, e); end
        checks++;
        if (hs_a !== 1'b1 || hs_c !== 1'b0) begin
            errors++; $display("FAIL reset_sync_level got hs_a=%b hs_c=%b want 1 0", hs_a, hs_c);
        end
        en_a = 0; en_b = 0; en_c = 0;
        step();
    endtask

    task automatic test_first_pixel();
        px_t o, e;
        rst_a = 1; en_a = 1;
        step();
        o = obs_a(); e = exp_a(); checks++;
        if (o !== e) begin errors++; $display("FAIL first_pixel_model got %h want %h", o, e); end
        checks++;
        if (hcs_a !== 0 || vcs_a !== 0 || hs_a !== 0 || vs_a !== 0 || fs_a !== 1 || ls_a !== 1 || av_a !== 0)
        begin
            errors++;
            $display("FAIL first_pixel got hcs=%0d vcs=%0d hs=%b vs=%b fs=%b ls=%b av=%b want 0 0 0 0 1 1 0",
                     hcs_a, vcs_a, hs_a, vs_a, fs_a, ls_a, av_a);
        end
        step();
        checks++;
        if (fs_a !== 0 || hcs_a !== 1) begin
            errors++; $display("FAIL first_pixel_pulse_end got fs=%b hcs=%0d want 0 1", fs_a, hcs_a);
        end
    endtask

    task automatic test_line_wrap();
        px_t o, e;
        int pulses = 0, hs_low5 = 0, hs_low_max = 0;
        bit saw_wrap = 0;
        logic [9:0] ph, pv;
        while (k_a < 6 * 800 + 10) begin
            ph = hcs_a; pv = vcs_a;
            step();
            o = obs_a(); e = exp_a(); checks++;
            if (o !== e) begin errors++; $display("FAIL line_wrap k=%0d got %h want %h", k_a, o, e); end
            if (ls_a) pulses++;
            if (vcs_a == 5 && hs_a == 0) begin hs_low5++; hs_low_max = int'(hcs_a); end
            if (ph == 799 && pv == 5 && hcs_a == 0 && vcs_a == 6) saw_wrap = 1;
        end
        checks++;
        if (!saw_wrap) begin errors++; $display("FAIL line_wrap_5_to_6 got 0 want 1"); end
        checks++;
        if (pulses != 6) begin errors++; $display("FAIL line_start_count got %0d want 6", pulses); end
        checks++;
        if (hs_low5 != 96 || hs_low_max != 95) begin
            errors++; $display("FAIL hsync_low_width got %0d last %0d want 96 last 95", hs_low5, hs_low_max);
        end
    endtask

    task automatic test_pix_en_div4();
        px_t o, e;
        int phase, last_ls = -1, gaps = 0;
        phase = int'($urandom_range(0, 3));
        for (int cyc = 0; cyc < 800 * 4 * 2 + 16; cyc++) begin
            en_a = ((cyc % 4) == phase);
            step();
            o = obs_a(); e = exp_a(); checks++;
            if (o !== e) begin errors++; $display("FAIL div4 cyc=%0d got %h want %h", cyc, o, e); end
            if (ls_a) begin
                if (last_ls >= 0) begin
                    gaps++; checks++;
                    if (cyc - last_ls != 3200) begin
                        errors++; $display("FAIL div4_line_period got %0d want 3200", cyc - last_ls);
                    end
                end
                last_ls = cyc;
            end
        end
        checks++;
        if (gaps < 1) begin errors++; $display("FAIL div4_line_pulses got %0d gaps want >=1", gaps); end
        en_a = 0;
    endtask

    task automatic test_frame_wrap();
        px_t o, e;
        int fs_seen = 0, last_fs = -1, vs_low = 0, edges = 0;
        rst_b = 1; en_b = 1;
        for (int cyc = 0; cyc < 2 * 4840 + 20; cyc++) begin
            step();
            o = obs_b(); e = exp_b(); checks++;
            if (o !== e) begin errors++; $display("FAIL frame_b cyc=%0d got %h want %h", cyc, o, e); end
            if (fs_b) begin
                if (last_fs >= 0) begin
                    checks++;
                    if (cyc - last_fs != 4840) begin
                        errors++; $display("FAIL frame_period got %0d want 4840", cyc - last_fs);
                    end
                end
                fs_seen++;
                last_fs = cyc;
            end
            if (fs_seen == 1 && vs_b == 0) vs_low++;
            if (hcs_b == 19 && vcs_b == 5) begin
                edges++; checks++;
                if (av_b !== 0) begin errors++; $display("FAIL edge_19_5 got av=%b want 0", av_b); end
            end
            if (hcs_b == 20 && vcs_b == 5) begin
                edges++; checks++;
                if (av_b !== 1 || x_b !== 0 || y_b !== 0) begin
                    errors++; $display("FAIL edge_20_5 got av=%b x=%0d y=%0d want 1 0 0", av_b, x_b, y_b);
                end
            end
            if (hcs_b == 83 && vcs_b == 52) begin
                edges++; checks++;
                if (av_b !== 1 || x_b !== 63 || y_b !== 47) begin
                    errors++; $display("FAIL edge_83_52 got av=%b x=%0d y=%0d want 1 63 47", av_b, x_b, y_b);
                end
            end
            if (hcs_b == 84 && vcs_b == 52) begin
                edges++; checks++;
                if (av_b !== 0 || x_b !== 0) begin
                    errors++; $display("FAIL edge_84_52 got av=%b x=%0d want 0 0", av_b, x_b);
                end
            end
        end
        checks++;
        if (fs_seen != 3) begin errors++; $display("FAIL frame_start_count got %0d want 3", fs_seen); end
        checks++;
        if (vs_low != 176) begin errors++; $display("FAIL vsync_low_ticks got %0d want 176", vs_low); end
        checks++;
        if (edges != 8) begin errors++; $display("FAIL window_edges_visited got %0d want 8", edges); end
        en_b = 0;
    endtask

    task automatic test_random_en();
        px_t o, e;
        rst_c = 1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            en_c = 1'($urandom_range(0, 1));
            step();
            o = obs_c(); e = exp_c(); checks++;
            if (o !== e) begin errors++; $display("FAIL rand_en cyc=%0d got %h want %h", cyc, o, e); end
        end
    endtask

    task automatic test_reset_midline();
        px_t o, e;
        int guard = 0, hs_hi = 0;
        bit in_line = 0;
        en_c = 1;
        while (!(in_line && hcs_c == 9) && guard < 100) begin
            step();
            guard++;
            if (ls_c) begin in_line = 1; hs_hi = 0; end
            if (in_line && hs_c) hs_hi++;
        end
        checks++;
        if (guard >= 100) begin errors++; $display("FAIL midline_reach_hcs9 got timeout want hcs=9"); end
        checks++;
        if (hs_hi != 2) begin errors++; $display("FAIL hsync_high_width got %0d want 2", hs_hi); end
        rst_c = 0; k_c = 0; last_c = 0;
        #1;
        o = obs_c(); e = exp_c(); checks++;
        if (o !== e) begin errors++; $display("FAIL midline_async_reset got %h want %h", o, e); end
        checks++;
        if (hcs_c !== 0 || hs_c !== 0 || vs_c !== 1 || ls_c !== 0) begin
            errors++; $display("FAIL midline_reset_levels got hcs=%0d hs=%b vs=%b ls=%b want 0 0 1 0",
                               hcs_c, hs_c, vs_c, ls_c);
        end
        @(negedge clk);
        step(); step();
        o = obs_c(); e = exp_c(); checks++;
        if (o !== e) begin errors++; $display("FAIL reset_held got %h want %h", o, e); end
        rst_c = 1;
        step();
        o = obs_c(); e = exp_c(); checks++;
        if (o !== e) begin errors++; $display("FAIL restart_model got %h want %h", o, e); end
        checks++;
        if (hcs_c !== 0 || vcs_c !== 0 || fs_c !== 1 || hs_c !== 1) begin
            errors++; $display("FAIL restart got hcs=%0d vcs=%0d fs=%b hs=%b want 0 0 1 1",
                               hcs_c, vcs_c, fs_c, hs_c);
        end
        for (int i = 0; i < 30; i++) begin
            step();
            o = obs_c(); e = exp_c(); checks++;
            if (o !== e) begin errors++; $display("FAIL after_restart i=%0d got %h want %h", i, o, e); end
        end
    endtask

    initial begin
        k_a = 0; k_b = 0; k_c = 0;
        last_a = 0; last_b = 0; last_c = 0;
        test_reset();
        test_first_pixel();
        test_line_wrap();
        test_pix_en_div4();
        test_frame_wrap();
        test_random_en();
        test_reset_midline();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
